// File: rtl/lab4d_shout_reader_pkg.sv
// Shared types and constants for the LAB4D SHOUT read-back engine.
// Holds the FSM encoding, chip-array geometry and the SCLK prescale clamp.
package lab4d_shout_reader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOW  = 2'd1,
        ST_HIGH = 2'd2,
        ST_DONE = 2'd3
    } rd_state_e;

    localparam int LAB4D_NUM_LAB  = 12;
    localparam int LAB4D_WORD_W   = 24;
    localparam int PRESCALE_W     = 8;
    localparam int KCNT_W         = 5;
    localparam int SEL_W          = 4;

    // Default synchronizer depth; also the floor applied to the prescale so
    // a sampled SHOUT bit has always cleared the synchronizer after a shift.
    localparam int PRESCALE_MIN_DEF = 2;

    function automatic logic [PRESCALE_W-1:0] clamp_prescale(
        input logic [PRESCALE_W-1:0] p,
        input logic [PRESCALE_W-1:0] p_min
    );
        return (p < p_min) ? p_min : p;
    endfunction

endpackage

// File: rtl/lab4d_shout_sync.sv
// Multi-bit flop synchronizer for the LAB4D SHOUT lines.
// Each bit runs through STAGES flops independently; no bus coherence implied.
module lab4d_shout_sync #(
    parameter int WIDTH  = 12,
    parameter int STAGES = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [STAGES-1:0][WIDTH-1:0] ff;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ff <= '0;
        end else begin
            ff[0] <= d;
            for (int s = 1; s < STAGES; s++) begin
                ff[s] <= ff[s-1];
            end
        end
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/lab4d_shout_reader.sv
// LAB4D serial-chain read-back: clocks SCLK to all chips in parallel and
// shifts each chip's synchronized SHOUT into a per-chip capture register.
module lab4d_shout_reader
    import lab4d_shout_reader_pkg::*;
#(
    parameter int NUM_LAB    = LAB4D_NUM_LAB,
    parameter int NBITS      = LAB4D_WORD_W,
    parameter int SHOUT_SYNC = PRESCALE_MIN_DEF
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [PRESCALE_W-1:0] prescale_i,
    input  logic [SEL_W-1:0]      sel_i,
    input  logic [NUM_LAB-1:0]    SHOUT,
    output logic                  sclk_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [NBITS-1:0]      data_o
);

    localparam logic [PRESCALE_W-1:0] PE_MIN = PRESCALE_W'(SHOUT_SYNC);
    localparam logic [KCNT_W-1:0]     K_LAST = KCNT_W'(NBITS - 1);

    rd_state_e                       state;
    logic [PRESCALE_W-1:0]           pe;
    logic [PRESCALE_W-1:0]           phase;
    logic [KCNT_W-1:0]               k;
    logic [NUM_LAB-1:0][NBITS-1:0]   capture;
    logic [NUM_LAB-1:0]              shout_s;

    lab4d_shout_sync #(
        .WIDTH  (NUM_LAB),
        .STAGES (SHOUT_SYNC)
    ) u_sync (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d     (SHOUT),
        .q     (shout_s)
    );

    // sclk_o/busy_o/done_o are set on the transition into the state they
    // describe, so they are plain flops with no decode glitches.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= ST_IDLE;
            pe      <= '0;
            phase   <= '0;
            k       <= '0;
            capture <= '0;
            sclk_o  <= 1'b0;
            busy_o  <= 1'b0;
            done_o  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done_o <= 1'b0;
                    sclk_o <= 1'b0;
                    if (start_i) begin
                        pe      <= clamp_prescale(prescale_i, PE_MIN);
                        phase   <= clamp_prescale(prescale_i, PE_MIN);
                        k       <= '0;
                        capture <= '0;
                        busy_o  <= 1'b1;
                        state   <= ST_LOW;
                    end
                end
                ST_LOW: begin
                    if (phase == '0) begin
                        // Sample just before the rising edge that shifts the chip.
                        for (int n = 0; n < NUM_LAB; n++) begin
                            capture[n] <= {capture[n][NBITS-2:0], shout_s[n]};
                        end
                        phase  <= pe;
                        sclk_o <= 1'b1;
                        state  <= ST_HIGH;
                    end else begin
                        phase <= phase - 1'b1;
                    end
                end
                ST_HIGH: begin
                    if (phase == '0) begin
                        sclk_o <= 1'b0;
                        if (k == K_LAST) begin
                            busy_o <= 1'b0;
                            done_o <= 1'b1;
                            state  <= ST_DONE;
                        end else begin
                            k     <= k + 1'b1;
                            phase <= pe;
                            state <= ST_LOW;
                        end
                    end else begin
                        phase <= phase - 1'b1;
                    end
                end
                ST_DONE: begin
                    done_o <= 1'b0;
                    state  <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        data_o = '0;
        for (int n = 0; n < NUM_LAB; n++) begin
            if (sel_i == SEL_W'(n)) begin
                data_o = capture[n];
            end
        end
    end

endmodule
